mario_motion_controller: RTL and testbench

Per-frame player kinematics stage sitting directly upstream of the game-logic block: it conditions the left/right switches and jump pushbutton, advances Mario's position once per video frame, and drives the `mario_x`/`mario_y` coordinates consumed by game logic and the VGA renderer. It runs a three-state vertical FSM (ground/rising/falling) with integer gravity, clamps Mario to the screen and floor, and exposes sprite-facing and airborne flags.

---
 rtl/mario_motion_controller.sv | 148 ++++++++++++++
 tb/tb_mario_motion_controller.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mario_motion_controller.sv
// mario_motion_controller: per-frame walk/jump kinematics with debounced jump and screen/floor clamping
module mario_motion_controller #(
    parameter int CHARACTER_WIDTH = 42,
    parameter int SCREEN_WIDTH    = 640,
    parameter int FLOOR_Y         = 398,
    parameter int START_X         = 40,
    parameter int WALK_SPEED      = 2,
    parameter int JUMP_VELOCITY   = 12,
    parameter int GRAVITY         = 1,
    parameter int MAX_FALL        = 12,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic        i_vga_clock,
    input  logic        i_reset,
    input  logic        i_left_switch,
    input  logic        i_right_switch,
    input  logic        i_jump_button,
    input  logic        i_vsync,
    input  logic        i_enable,
    output logic [31:0] o_mario_x,
    output logic [31:0] o_mario_y,
    output logic        o_airborne,
    output logic        o_facing_left
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int X_MAX = SCREEN_WIDTH - CHARACTER_WIDTH;

    typedef enum logic [1:0] {GROUND, RISING, FALLING} state_t;

    state_t             r_state, w_state_nxt;
    logic signed [31:0] r_x, r_y, r_vel;
    logic signed [31:0] w_x_nxt, w_y_nxt, w_vel_nxt, w_ny;
    logic               r_face, w_face_nxt;
    logic               r_jb_s1, r_jb_s2, r_jb_db, r_db_prev;
    logic [CW-1:0]      r_db_cnt;
    logic               r_vsync_q, r_jump_req;
    logic               w_tick, w_press, w_move;

    assign w_tick  = r_vsync_q & ~i_vsync;
    assign w_press = r_db_prev & ~r_jb_db;
    assign w_move  = w_tick & i_enable;
    assign w_ny    = r_y + r_vel;

    // Synchronize and debounce the active-low jump button; the level flips only after a full stable window
    always_ff @(posedge i_vga_clock) begin
        if (!i_reset) begin
            r_jb_s1   <= 1'b1;
            r_jb_s2   <= 1'b1;
            r_jb_db   <= 1'b1;
            r_db_prev <= 1'b1;
            r_db_cnt  <= '0;
        end else begin
            r_jb_s1   <= i_jump_button;
            r_jb_s2   <= r_jb_s1;
            r_db_prev <= r_jb_db;
            if (r_jb_s2 == r_jb_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_jb_db  <= r_jb_s2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // Frame tick edge detect and jump request latch; a tick consumes the old request and keeps only a coincident press
    always_ff @(posedge i_vga_clock) begin
        if (!i_reset) begin
            r_vsync_q  <= 1'b0;
            r_jump_req <= 1'b0;
        end else begin
            r_vsync_q  <= i_vsync;
            r_jump_req <= !i_enable ? 1'b0 : w_tick ? w_press : (r_jump_req | w_press);
        end
    end

    // Motion state register
    always_ff @(posedge i_vga_clock) begin
        if (!i_reset) begin
            r_state <= GROUND;
            r_x     <= START_X;
            r_y     <= FLOOR_Y;
            r_vel   <= '0;
            r_face  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_vel   <= w_vel_nxt;
            r_face  <= w_face_nxt;
        end
    end

    // Per-tick horizontal walk and vertical ground/rising/falling transitions; comparisons precede subtractions
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_vel_nxt   = r_vel;
        w_face_nxt  = r_face;
        if (w_move) begin
            if (i_left_switch && !i_right_switch) begin
                w_x_nxt    = (r_x < WALK_SPEED) ? '0 : r_x - WALK_SPEED;
                w_face_nxt = 1'b1;
            end else if (i_right_switch && !i_left_switch) begin
                w_x_nxt    = (r_x > X_MAX - WALK_SPEED) ? X_MAX : r_x + WALK_SPEED;
                w_face_nxt = 1'b0;
            end
            case (r_state)
                GROUND: begin
                    w_y_nxt = FLOOR_Y;
                    if (r_jump_req) begin
                        w_vel_nxt   = JUMP_VELOCITY;
                        w_state_nxt = RISING;
                    end
                end
                RISING: begin
                    if (r_y < r_vel) begin
                        w_y_nxt     = '0;
                        w_vel_nxt   = '0;
                        w_state_nxt = FALLING;
                    end else begin
                        w_y_nxt     = r_y - r_vel;
                        w_vel_nxt   = (r_vel <= GRAVITY) ? '0 : r_vel - GRAVITY;
                        w_state_nxt = (r_vel <= GRAVITY) ? FALLING : RISING;
                    end
                end
                FALLING: begin
                    if (w_ny >= FLOOR_Y) begin
                        w_y_nxt     = FLOOR_Y;
                        w_vel_nxt   = '0;
                        w_state_nxt = GROUND;
                    end else begin
                        w_y_nxt   = w_ny;
                        w_vel_nxt = (r_vel + GRAVITY > MAX_FALL) ? MAX_FALL : r_vel + GRAVITY;
                    end
                end
                default: w_state_nxt = GROUND;
            endcase
        end
    end

    assign o_mario_x     = r_x;
    assign o_mario_y     = r_y;
    assign o_airborne    = (r_state != GROUND);
    assign o_facing_left = r_face;
endmodule

// File: tb/tb_mario_motion_controller.sv
// tb_mario_motion_controller: table-driven walk vectors plus directed jump, freeze and reset sequences
module tb_mario_motion_controller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        left = 1'b0, right = 1'b0, jb = 1'b1, vsync = 1'b1, en = 1'b1;
    logic [31:0] x, y, xr, yr;
    logic        air, fl, air_r, fl_r;
    int          n_cmp = 0, n_bad = 0;

    typedef struct {
        logic l;
        logic r;
        int   ticks;
        int   ex;
        int   efl;
        int   exr;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    mario_motion_controller #(.DEBOUNCE_CYCLES(4)) dut (
        .i_vga_clock(clk), .i_reset(rst_n), .i_left_switch(left), .i_right_switch(right),
        .i_jump_button(jb), .i_vsync(vsync), .i_enable(en),
        .o_mario_x(x), .o_mario_y(y), .o_airborne(air), .o_facing_left(fl)
    );

    mario_motion_controller #(.DEBOUNCE_CYCLES(4), .START_X(590)) dut_r (
        .i_vga_clock(clk), .i_reset(rst_n), .i_left_switch(left), .i_right_switch(right),
        .i_jump_button(jb), .i_vsync(vsync), .i_enable(en),
        .o_mario_x(xr), .o_mario_y(yr), .o_airborne(air_r), .o_facing_left(fl_r)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) vsync = 1'b0;
            @(negedge clk) vsync = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic press(input int n);
        @(negedge clk) jb = 1'b0;
        repeat (n) @(negedge clk);
        jb = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 5, 40, 0, 590};
        vecs[1] = '{1'b0, 1'b1, 10, 60, 0, 598};
        vecs[2] = '{1'b1, 1'b0, 40, 0, 1, 518};
        vecs[3] = '{1'b1, 1'b1, 3, 0, 1, 518};
        vecs[4] = '{1'b0, 1'b1, 5, 10, 0, 528};
        vecs[5] = '{1'b1, 1'b1, 3, 10, 0, 528};
        vecs[6] = '{1'b1, 1'b0, 1, 8, 1, 526};
        vecs[7] = '{1'b0, 1'b0, 2, 8, 1, 526};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_x", x, 40);
        chk("reset_y", y, 398);
        chk("reset_air", air, 0);
        chk("reset_face", fl, 0);

        for (int v = 0; v < 8; v++) begin
            left  = vecs[v].l;
            right = vecs[v].r;
            tick(vecs[v].ticks);
            chk($sformatf("vec%0d_x", v), x, vecs[v].ex);
            chk($sformatf("vec%0d_face", v), fl, vecs[v].efl);
            chk($sformatf("vec%0d_y", v), y, 398);
            chk($sformatf("vec%0d_air", v), air, 0);
            chk($sformatf("vec%0d_xr", v), xr, vecs[v].exr);
        end
        left  = 1'b0;
        right = 1'b0;

        press(2);
        tick(1);
        chk("glitch_y", y, 398);
        chk("glitch_air", air, 0);

        press(10);
        tick(1);
        chk("launch_y", y, 398);
        chk("launch_air", air, 1);
        tick(1);
        chk("rise1_y", y, 386);
        tick(11);
        chk("peak_y", y, 320);
        chk("peak_air", air, 1);
        tick(12);
        chk("prelanding_y", y, 386);
        chk("prelanding_air", air, 1);
        tick(1);
        chk("land_y", y, 398);
        chk("land_air", air, 0);

        press(10);
        tick(4);
        chk("pre_freeze_y", y, 365);
        en    = 1'b0;
        right = 1'b1;
        tick(5);
        chk("freeze_y", y, 365);
        chk("freeze_x", x, 8);
        chk("freeze_air", air, 1);
        chk("freeze_face", fl, 1);
        en    = 1'b1;
        right = 1'b0;
        tick(1);
        chk("resume_y", y, 356);
        press(10);
        tick(21);
        chk("land2_y", y, 398);
        chk("land2_air", air, 0);
        tick(3);
        chk("nobuffer_y", y, 398);
        chk("nobuffer_air", air, 0);
        chk("nobuffer_x", x, 8);

        press(10);
        tick(13);
        chk("peak3_y", y, 320);
        chk("peak3_air", air, 1);
        @(negedge clk);
        rst_n = 1'b0;
        vsync = 1'b0;
        @(negedge clk);
        chk("midreset_y", y, 398);
        chk("midreset_air", air, 0);
        chk("midreset_x", x, 40);
        chk("midreset_xr", xr, 590);
        rst_n = 1'b1;
        right = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_spurious_tick_x", x, 40);
        vsync = 1'b1;
        @(negedge clk);
        tick(1);
        chk("post_reset_tick_x", x, 42);
        chk("post_reset_tick_y", y, 398);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
